// File: rtl/uart_dev.sv
// uart_dev: register-mapped UART with a 4-deep TX FIFO. Define UART_DEV_RX_FIFO_EN
// for a 4-deep RX FIFO; otherwise RX storage is a single holding register.
`ifndef UartDataWidth
`define UartDataWidth 8
`endif

module uart_dev #(
  parameter int CLK_DIV = 434
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rd,
  input  logic                      uart_wr,
  input  logic [1:0]                uart_addr,
  input  logic [`UartDataWidth-1:0] uart_din,
  output logic [`UartDataWidth-1:0] uart_dout,
  output logic                      tx,
  input  logic                      rx
);
`ifdef UART_DEV_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif
  localparam int TX_DEPTH = 4;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [7:0]  tx_mem_q [TX_DEPTH];
  logic [7:0]  tx_mem_d [TX_DEPTH];
  logic [7:0]  rx_mem_q [RX_DEPTH];
  logic [7:0]  rx_mem_d [RX_DEPTH];
  logic [2:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [15:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0]  rx_sync_q, rx_sync_d;
  logic [7:0]  dout_q, dout_d;
  logic        tx_q, tx_d, fe_q, fe_d, ovf_q, ovf_d;
  logic        wr0, wr2, tx_push, tx_pop, tx_full, tx_empty, tx_tick;
  logic        rx_tick, rx_done, rx_push, rx_pop, rx_in, rx_full, rx_valid;
  logic [7:0]  status;

  assign wr0      = uart_wr && uart_addr == 2'd0;
  assign wr2      = uart_wr && uart_addr == 2'd2;
  assign tx_full  = tx_cnt_q == 3'(TX_DEPTH);
  assign tx_empty = tx_cnt_q == 3'd0 && tx_st_q == IDLE;
  assign tx_push  = wr0 && !tx_full;
  assign tx_tick  = tx_baud_q == 16'd0;
  assign rx_full  = rx_cnt_q == 3'(RX_DEPTH);
  assign rx_valid = rx_cnt_q != 3'd0;
  assign rx_pop   = uart_rd && uart_addr == 2'd0 && rx_valid;
  assign rx_tick  = rx_baud_q == 16'd0;
  assign status   = {3'b0, fe_q, ovf_q, tx_full, tx_empty, rx_valid};
  assign uart_dout = dout_q;
  assign tx        = tx_q;

  // A pending byte at the end of STOP goes straight to START, so frames stay back to back.
  always_comb begin
    tx_st_d = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      IDLE:  tx_pop = tx_cnt_q != 3'd0;
      START: if (tx_tick) begin
               tx_st_d = DATA;
               tx_bit_d = 3'd0;
             end
      DATA:  if (tx_tick) begin
               tx_sh_d = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_st_d = STOP;
             end
      STOP:  if (tx_tick) begin
               tx_st_d = IDLE;
               tx_pop = tx_cnt_q != 3'd0;
             end
    endcase
    if (tx_pop) begin
      tx_st_d = START;
      tx_sh_d = tx_mem_q[0];
    end
    tx_baud_d = (tx_st_q == IDLE && !tx_pop) ? 16'd0 : tx_tick ? DIV_M1 : tx_baud_q - 16'd1;
    tx_d = tx_st_d == START ? 1'b0 : tx_st_d == DATA ? tx_sh_d[0] : 1'b1;
    tx_mem_d = tx_mem_q;
    if (tx_pop) for (int i = 0; i < TX_DEPTH - 1; i++) tx_mem_d[i] = tx_mem_q[i + 1];
    for (int i = 0; i < TX_DEPTH; i++)
      if (tx_push && i == int'(tx_cnt_q) - int'(tx_pop)) tx_mem_d[i] = uart_din;
    tx_cnt_d = tx_cnt_q + {2'b0, tx_push} - {2'b0, tx_pop};
  end

  // rx_sync_q[1] is the synchronized line, rx_sync_q[2] its previous value for edge detection.
  always_comb begin
    rx_sync_d = {rx_sync_q[1:0], rx};
    rx_st_d = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_done = 1'b0;
    rx_baud_d = rx_st_q == IDLE ? 16'd0 : rx_tick ? DIV_M1 : rx_baud_q - 16'd1;
    case (rx_st_q)
      IDLE:  if (rx_sync_q[2] && !rx_sync_q[1]) begin
               rx_st_d = START;
               rx_baud_d = HALF_M1;
             end
      START: if (rx_tick) begin
               rx_st_d = rx_sync_q[1] ? IDLE : DATA;
               rx_bit_d = 3'd0;
             end
      DATA:  if (rx_tick) begin
               rx_sh_d = {rx_sync_q[1], rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = STOP;
             end
      STOP:  if (rx_tick) begin
               rx_st_d = IDLE;
               rx_done = 1'b1;
             end
    endcase
    rx_push = rx_done && rx_sync_q[1];
    rx_in = rx_push && (!rx_full || rx_pop);
    rx_mem_d = rx_mem_q;
    if (rx_pop) for (int i = 0; i < RX_DEPTH - 1; i++) rx_mem_d[i] = rx_mem_q[i + 1];
    for (int i = 0; i < RX_DEPTH; i++)
      if (rx_in && i == int'(rx_cnt_q) - int'(rx_pop)) rx_mem_d[i] = rx_sh_q;
    rx_cnt_d = rx_cnt_q + {2'b0, rx_in} - {2'b0, rx_pop};
    ovf_d = (ovf_q && !(wr2 && uart_din[0])) || (rx_push && rx_full && !rx_pop);
    fe_d = (fe_q && !(wr2 && uart_din[1])) || (rx_done && !rx_sync_q[1]);
    dout_d = !uart_rd ? dout_q :
             uart_addr == 2'd0 ? (rx_valid ? rx_mem_q[0] : 8'h00) :
             uart_addr == 2'd1 ? status :
             uart_addr == 2'd3 ? 8'hA5 : 8'h00;
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
    tx_bit_q <= tx_bit_d;
    rx_bit_q <= rx_bit_d;
    if (rst) begin
      tx_st_q <= IDLE;
      rx_st_q <= IDLE;
      tx_cnt_q <= 3'd0;
      rx_cnt_q <= 3'd0;
      tx_baud_q <= 16'd0;
      rx_baud_q <= 16'd0;
      rx_sync_q <= 3'b111;
      dout_q <= 8'h00;
      tx_q <= 1'b1;
      fe_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_baud_q <= tx_baud_d;
      rx_baud_q <= rx_baud_d;
      rx_sync_q <= rx_sync_d;
      dout_q <= dout_d;
      tx_q <= tx_d;
      fe_q <= fe_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
